// File: rtl/cp0_regfile_if.sv
// Pipeline-to-CP0 bus: MTC0/MFC0 access, MEM-stage exception inputs and the
// status/cause/epc view returned to the exception unit.
interface cp0_regfile_if;
   logic        we;
   logic [4:0]  waddr;
   logic [4:0]  raddr;
   logic [31:0] wdata;
   logic [5:0]  int_hard;
   logic [31:0] except_type;
   logic [31:0] pcM;
   logic        is_in_delayslotM;
   logic [31:0] badvaddrM;
   logic [31:0] rdata;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_epc;
   logic        timer_int;

   modport master (
      output we, waddr, raddr, wdata, int_hard, except_type, pcM,
             is_in_delayslotM, badvaddrM,
      input  rdata, cp0_status, cp0_cause, cp0_epc, timer_int
   );

   modport slave (
      input  we, waddr, raddr, wdata, int_hard, except_type, pcM,
             is_in_delayslotM, badvaddrM,
      output rdata, cp0_status, cp0_cause, cp0_epc, timer_int
   );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: exception commit, ERET, MTC0/MFC0 and the
// Count/Compare timer. Exception/ERET commit takes priority over MTC0.
`ifndef CP0_EXC_TYPES_DEFINED
`define CP0_EXC_TYPES_DEFINED
`define EXC_TYPE_NOEXC 32'h0000_0000
`define EXC_TYPE_INT   32'h0000_0001
`define EXC_TYPE_ADEL  32'h0000_0004
`define EXC_TYPE_ADES  32'h0000_0005
`define EXC_TYPE_SYS   32'h0000_0008
`define EXC_TYPE_BP    32'h0000_0009
`define EXC_TYPE_RI    32'h0000_000a
`define EXC_TYPE_OV    32'h0000_000c
`define EXC_TYPE_ERET  32'h0000_000e
`endif

module cp0_regfile #(
   parameter int COUNT_DIV = 2
) (
   input  logic          clk,
   input  logic          rst,
   cp0_regfile_if.slave  bus
);

   localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
   localparam bit          DIV_ONE      = (COUNT_DIV == 32'd1);

   logic [31:0] badvaddr_r, count_r, compare_r, status_r, cause_r, epc_r;
   logic        tick_r;

   logic [31:0] badvaddr_nxt_s, count_nxt_s, compare_nxt_s;
   logic [31:0] status_nxt_s, cause_nxt_s, epc_nxt_s, rdata_s;
   logic        tick_nxt_s, tick_s, exc_s, eret_s, wr_s, match_s, addr_exc_s;
   logic [4:0]  exccode_s;

   // Classify the MEM-stage event and map the exception type to ExcCode.
   always_comb begin
      exc_s      = (bus.except_type != `EXC_TYPE_NOEXC) && (bus.except_type != `EXC_TYPE_ERET);
      eret_s     = (bus.except_type == `EXC_TYPE_ERET);
      wr_s       = bus.we && (bus.except_type == `EXC_TYPE_NOEXC);
      match_s    = (count_r == compare_r);
      tick_s     = DIV_ONE ? 1'b1 : tick_r;
      addr_exc_s = (bus.except_type == `EXC_TYPE_ADEL) || (bus.except_type == `EXC_TYPE_ADES);
      case (bus.except_type)
         `EXC_TYPE_INT:  exccode_s = 5'h00;
         `EXC_TYPE_ADEL: exccode_s = 5'h04;
         `EXC_TYPE_ADES: exccode_s = 5'h05;
         `EXC_TYPE_SYS:  exccode_s = 5'h08;
         `EXC_TYPE_BP:   exccode_s = 5'h09;
         `EXC_TYPE_RI:   exccode_s = 5'h0a;
         `EXC_TYPE_OV:   exccode_s = 5'h0c;
         default:        exccode_s = cause_r[6:2];
      endcase
   end

   // Next-state: timer and hardware IP every cycle, then commit or MTC0.
   always_comb begin
      badvaddr_nxt_s      = badvaddr_r;
      compare_nxt_s       = compare_r;
      status_nxt_s        = status_r;
      epc_nxt_s           = epc_r;
      cause_nxt_s         = cause_r;
      cause_nxt_s[15:10]  = {bus.int_hard[5] | cause_r[30], bus.int_hard[4:0]};
      tick_nxt_s          = DIV_ONE ? 1'b0 : ~tick_r;
      if (match_s) begin
         cause_nxt_s[30] = 1'b1;
      end else begin
         cause_nxt_s[30] = cause_r[30];
      end
      if (tick_s) begin
         count_nxt_s = count_r + 32'd1;
      end else begin
         count_nxt_s = count_r;
      end

      if (exc_s) begin
         // A nested exception keeps the EPC/BD of the outermost one.
         if (!status_r[1]) begin
            epc_nxt_s       = bus.is_in_delayslotM ? (bus.pcM - 32'd4) : bus.pcM;
            cause_nxt_s[31] = bus.is_in_delayslotM;
         end else begin
            epc_nxt_s       = epc_r;
            cause_nxt_s[31] = cause_r[31];
         end
         status_nxt_s[1]  = 1'b1;
         cause_nxt_s[6:2] = exccode_s;
         if (addr_exc_s) begin
            badvaddr_nxt_s = bus.badvaddrM;
         end else begin
            badvaddr_nxt_s = badvaddr_r;
         end
      end else if (eret_s) begin
         status_nxt_s[1] = 1'b0;
      end else if (wr_s) begin
         case (bus.waddr)
            5'd9:    count_nxt_s   = bus.wdata;
            5'd11: begin
               compare_nxt_s   = bus.wdata;
               cause_nxt_s[30] = 1'b0;
            end
            5'd12:   status_nxt_s  = (status_r & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
            5'd13:   cause_nxt_s   = (cause_nxt_s & ~CAUSE_WMASK) | (bus.wdata & CAUSE_WMASK);
            5'd14:   epc_nxt_s     = bus.wdata;
            default: epc_nxt_s     = epc_r;
         endcase
      end else begin
         epc_nxt_s = epc_r;
      end
   end

   // State registers with synchronous reset overriding everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         badvaddr_r <= 32'h0000_0000;
         count_r    <= 32'h0000_0000;
         compare_r  <= 32'h0000_0000;
         status_r   <= STATUS_RST;
         cause_r    <= 32'h0000_0000;
         epc_r      <= 32'h0000_0000;
         tick_r     <= 1'b0;
      end else begin
         badvaddr_r <= badvaddr_nxt_s;
         count_r    <= count_nxt_s;
         compare_r  <= compare_nxt_s;
         status_r   <= status_nxt_s;
         cause_r    <= cause_nxt_s;
         epc_r      <= epc_nxt_s;
         tick_r     <= tick_nxt_s;
      end
   end

   // MFC0 read port shows pre-update state; no write-through bypass.
   always_comb begin
      case (bus.raddr)
         5'd8:    rdata_s = badvaddr_r;
         5'd9:    rdata_s = count_r;
         5'd11:   rdata_s = compare_r;
         5'd12:   rdata_s = status_r;
         5'd13:   rdata_s = cause_r;
         5'd14:   rdata_s = epc_r;
         default: rdata_s = 32'h0000_0000;
      endcase
   end

   assign bus.rdata      = rdata_s;
   assign bus.cp0_status = status_r;
   assign bus.cp0_cause  = cause_r;
   assign bus.cp0_epc    = epc_r;
   assign bus.timer_int  = cause_r[30];

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios then randomized traffic, all
// checked against a field-level reference model of the CP0 registers.
module tb_cp0_regfile;
   localparam int COUNT_DIV = 2;
   localparam logic [31:0] E_NOEXC = 32'h0, E_INT = 32'h1, E_ADEL = 32'h4, E_ADES = 32'h5;
   localparam logic [31:0] E_SYS = 32'h8, E_BP = 32'h9, E_RI = 32'ha, E_OV = 32'hc, E_ERET = 32'he;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #20 clk = ~clk;

   cp0_regfile_if bus ();
   cp0_regfile #(.COUNT_DIV(COUNT_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model kept as individual architectural fields.
   logic [31:0] m_badvaddr, m_count, m_compare, m_epc;
   logic [7:0]  m_im;
   logic        m_bev, m_exl, m_ie, m_bd, m_ti, m_phase;
   logic [5:0]  m_ip_hw;
   logic [1:0]  m_ip_sw;
   logic [4:0]  m_exccode;

   function automatic logic [31:0] m_status_word();
      return {9'd0, m_bev, 6'd0, m_im, 6'd0, m_exl, m_ie};
   endfunction

   function automatic logic [31:0] m_cause_word();
      return {m_bd, m_ti, 14'd0, m_ip_hw, m_ip_sw, 1'b0, m_exccode, 2'b00};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_badvaddr;
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status_word();
         5'd13:   return m_cause_word();
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [4:0] code_of(input logic [31:0] t);
      case (t)
         E_INT:   return 5'd0;
         E_ADEL:  return 5'd4;
         E_ADES:  return 5'd5;
         E_SYS:   return 5'd8;
         E_BP:    return 5'd9;
         E_RI:    return 5'd10;
         E_OV:    return 5'd12;
         default: return m_exccode;
      endcase
   endfunction

   task automatic m_reset();
      m_badvaddr = 32'h0; m_count = 32'h0; m_compare = 32'h0; m_epc = 32'h0;
      m_im = 8'h0; m_bev = 1'b1; m_exl = 1'b0; m_ie = 1'b0;
      m_bd = 1'b0; m_ti = 1'b0; m_ip_hw = 6'h0; m_ip_sw = 2'h0; m_exccode = 5'h0;
      m_phase = 1'b0;
   endtask

   task automatic m_step();
      logic match, wr, is_exc;
      if (rst) begin
         m_reset();
         return;
      end
      match  = (m_count == m_compare);
      wr     = bus.we && (bus.except_type == E_NOEXC);
      is_exc = (bus.except_type != E_NOEXC) && (bus.except_type != E_ERET);
      m_ip_hw = {bus.int_hard[5] | m_ti, bus.int_hard[4:0]};
      if (match) m_ti = 1'b1;
      if (m_phase) m_count = m_count + 32'd1;
      m_phase = ~m_phase;
      if (is_exc) begin
         if (!m_exl) begin
            m_epc = bus.is_in_delayslotM ? bus.pcM - 32'd4 : bus.pcM;
            m_bd  = bus.is_in_delayslotM;
         end
         m_exl = 1'b1;
         m_exccode = code_of(bus.except_type);
         if (bus.except_type == E_ADEL || bus.except_type == E_ADES) m_badvaddr = bus.badvaddrM;
      end else if (bus.except_type == E_ERET) begin
         m_exl = 1'b0;
      end else if (wr) begin
         case (bus.waddr)
            5'd9:  m_count = bus.wdata;
            5'd11: begin m_compare = bus.wdata; m_ti = 1'b0; end
            5'd12: begin m_im = bus.wdata[15:8]; m_exl = bus.wdata[1]; m_ie = bus.wdata[0]; end
            5'd13: m_ip_sw = bus.wdata[9:8];
            5'd14: m_epc = bus.wdata;
            default: ;
         endcase
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      bus.raddr = a;
      #1;
      v = bus.rdata;
   endtask

   // One clock: advance model with the applied inputs, then compare all state.
   task automatic cycle();
      logic [4:0]  addrs [7];
      logic [31:0] v;
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
      addrs[6] = 5'($urandom_range(0, 31));
      @(posedge clk);
      m_step();
      #1;
      foreach (addrs[i]) begin
         rd(addrs[i], v);
         check($sformatf("rdata[%0d]", addrs[i]), v, m_read(addrs[i]));
      end
      check("cp0_status", bus.cp0_status, m_status_word());
      check("cp0_cause", bus.cp0_cause, m_cause_word());
      check("cp0_epc", bus.cp0_epc, m_epc);
      check("timer_int", {31'd0, bus.timer_int}, {31'd0, m_ti});
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.except_type = E_NOEXC;
      cycle();
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.except_type = E_NOEXC;
      cycle();
      bus.we = 1'b0;
   endtask

   task automatic raise(input logic [31:0] t, input logic [31:0] pc, input logic dly,
                        input logic [31:0] bva);
      bus.except_type = t; bus.pcM = pc; bus.is_in_delayslotM = dly; bus.badvaddrM = bva;
      cycle();
      bus.except_type = E_NOEXC; bus.is_in_delayslotM = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      logic [4:0]  wsel [7];
      logic [31:0] etab [8];
      m_reset();
      bus.we = 1'b0; bus.waddr = 5'd0; bus.raddr = 5'd0; bus.wdata = 32'h0;
      bus.int_hard = 6'h0; bus.except_type = E_NOEXC; bus.pcM = 32'h0;
      bus.is_in_delayslotM = 1'b0; bus.badvaddrM = 32'h0;

      // Reset values
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      rd(5'd12, v); check("rst_status", v, 32'h0040_0000);
      rd(5'd8, v);  check("rst_badvaddr", v, 32'h0);
      rd(5'd9, v);  check("rst_count", v, 32'h0);
      rd(5'd11, v); check("rst_compare", v, 32'h0);
      rd(5'd13, v); check("rst_cause", v, 32'h0);
      rd(5'd14, v); check("rst_epc", v, 32'h0);
      check("rst_ti", {31'd0, bus.timer_int}, 32'd0);

      // Count/Compare timer
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      for (int i = 0; i < 40 && !bus.timer_int; i++) idle();
      check("ti_set", {31'd0, bus.timer_int}, 32'd1);
      idle();
      check("cause15_ti", {31'd0, bus.cp0_cause[15]}, 32'd1);
      mtc0(5'd11, 32'd9);
      check("ti_clear", {31'd0, bus.timer_int}, 32'd0);

      // SYS exception, then ERET with a discarded same-cycle MTC0
      mtc0(5'd12, 32'h0000_ff01);
      raise(E_SYS, 32'hbfc0_0100, 1'b0, 32'h0);
      check("sys_epc", bus.cp0_epc, 32'hbfc0_0100);
      check("sys_code", {27'd0, bus.cp0_cause[6:2]}, 32'h8);
      check("sys_bd", {31'd0, bus.cp0_cause[31]}, 32'd0);
      check("sys_exl", {31'd0, bus.cp0_status[1]}, 32'd1);
      bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'h0;
      raise(E_ERET, 32'h0, 1'b0, 32'h0);
      bus.we = 1'b0;
      check("eret_exl", {31'd0, bus.cp0_status[1]}, 32'd0);
      check("eret_im_ie", {16'd0, bus.cp0_status[15:8], 7'd0, bus.cp0_status[0]}, 32'h0000_ff01);

      // ADEL in delay slot, then nested exception keeps EPC
      raise(E_ADEL, 32'h8000_0010, 1'b1, 32'h1234_5679);
      check("adel_epc", bus.cp0_epc, 32'h8000_000c);
      check("adel_bd", {31'd0, bus.cp0_cause[31]}, 32'd1);
      rd(5'd8, v); check("adel_badvaddr", v, 32'h1234_5679);
      raise(E_OV, 32'h9000_0000, 1'b0, 32'hdead_beef);
      check("nested_epc", bus.cp0_epc, 32'h8000_000c);
      check("nested_code", {27'd0, bus.cp0_cause[6:2]}, 32'hc);
      rd(5'd8, v); check("nested_badvaddr", v, 32'h1234_5679);
      raise(E_ERET, 32'h0, 1'b0, 32'h0);

      // Count wrap and write-vs-tick
      mtc0(5'd9, 32'hffff_ffff);
      rd(5'd9, v);
      for (int i = 0; i < 4 && v != 32'h0; i++) begin
         idle();
         rd(5'd9, v);
      end
      check("count_wrap", v, 32'h0);
      mtc0(5'd9, 32'h1234_0000);
      rd(5'd9, v); check("count_wr_a", v, 32'h1234_0000);
      mtc0(5'd9, 32'h5678_0000);
      rd(5'd9, v); check("count_wr_b", v, 32'h5678_0000);

      // Randomized traffic
      wsel = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      etab = '{E_INT, E_ADEL, E_ADES, E_SYS, E_BP, E_RI, E_OV, E_ERET};
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         bus.we = ($urandom_range(0, 3) == 0);
         bus.waddr = wsel[$urandom_range(0, 6)];
         bus.wdata = $urandom;
         if (bus.waddr == 5'd11 && $urandom_range(0, 1) == 1)
            bus.wdata = m_count + 32'($urandom_range(0, 6));
         bus.except_type = ($urandom_range(0, 5) == 0) ? etab[$urandom_range(0, 7)] : E_NOEXC;
         bus.pcM = $urandom & 32'hffff_fffc;
         bus.is_in_delayslotM = $urandom_range(0, 1) == 1;
         bus.badvaddrM = $urandom;
         bus.int_hard = 6'($urandom);
         cycle();
      end
      rst = 1'b0;
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
